// File: rtl/fma_normalizer_pkg.sv
// Shared widths, state encoding and derived constants for the FMA post-addition normalizer.
package fma_normalizer_pkg;

  localparam int EXP_WIDTH = 8;
  localparam int SIG_WIDTH = 23;
  localparam int SUM_WIDTH = 3 * (SIG_WIDTH + 1) + 4;
  localparam int NORM_STEP = 8;

  localparam int SIG_OUT_W = SUM_WIDTH - 1;
  // Two spare bits so the carry increment never wraps.
  localparam int EXP_REG_W = EXP_WIDTH + 2;
  localparam logic [EXP_REG_W-1:0] EXP_MAX = EXP_REG_W'((1 << EXP_WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COARSE,
    ST_FINE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fma_normalizer_if.sv
// Input/output handshake bundle of the normalizer; master drives operands, slave is the normalizer.
interface fma_normalizer_if;
  import fma_normalizer_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SUM_WIDTH-1:0] sum_in;
  logic [EXP_WIDTH-1:0] exp_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [SIG_OUT_W-1:0] sig_out;
  logic [EXP_WIDTH-1:0] exp_out;
  logic                 sticky_out;
  logic                 is_zero;
  logic                 is_subnormal;
  logic                 overflow;

  modport master (
    output in_valid, sum_in, exp_in, out_ready,
    input  in_ready, out_valid, sig_out, exp_out, sticky_out, is_zero, is_subnormal, overflow
  );

  modport slave (
    input  in_valid, sum_in, exp_in, out_ready,
    output in_ready, out_valid, sig_out, exp_out, sticky_out, is_zero, is_subnormal, overflow
  );

endinterface

// File: rtl/fma_normalizer.sv
// Iterative post-addition normalizer: carry right shift on capture, then coarse and fine left
// shifts until the leading one reaches the MSB or the exponent floor is hit.
module fma_normalizer
  import fma_normalizer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  fma_normalizer_if.slave  bus
);

  localparam int MSB = SIG_OUT_W - 1;

  state_t               state_q, state_d;
  logic [SIG_OUT_W-1:0] sig_q, sig_d;
  logic [EXP_REG_W-1:0] exp_q, exp_d;
  logic [EXP_WIDTH-1:0] exp_out_q, exp_out_d;
  logic                 sticky_q, sticky_d;
  logic                 zero_q, zero_d;
  logic                 sub_q, sub_d;
  logic                 ovf_q, ovf_d;
  logic [EXP_REG_W-1:0] exp_inc;

  assign exp_inc = EXP_REG_W'(bus.exp_in) + EXP_REG_W'(1);

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    exp_d     = exp_q;
    exp_out_d = exp_out_q;
    sticky_d  = sticky_q;
    zero_d    = zero_q;
    sub_d     = sub_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          zero_d    = 1'b0;
          sub_d     = 1'b0;
          ovf_d     = 1'b0;
          exp_out_d = '0;
          if (bus.sum_in == '0) begin
            sig_d    = '0;
            exp_d    = '0;
            sticky_d = 1'b0;
            zero_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (bus.sum_in[SUM_WIDTH-1]) begin
            // Carry out of the adder: one right shift, the dropped bit feeds sticky.
            sig_d    = bus.sum_in[SUM_WIDTH-1:1];
            exp_d    = exp_inc;
            sticky_d = bus.sum_in[0];
            if (exp_inc >= EXP_MAX) begin
              ovf_d     = 1'b1;
              exp_out_d = '1;
              state_d   = ST_DONE;
            end else begin
              state_d = ST_COARSE;
            end
          end else begin
            sig_d    = bus.sum_in[SIG_OUT_W-1:0];
            exp_d    = EXP_REG_W'(bus.exp_in);
            sticky_d = 1'b0;
            state_d  = ST_COARSE;
          end
        end
      end
      ST_COARSE: begin
        if ((sig_q[MSB -: NORM_STEP] == '0) && (exp_q > EXP_REG_W'(NORM_STEP))) begin
          sig_d = sig_q << NORM_STEP;
          exp_d = exp_q - EXP_REG_W'(NORM_STEP);
        end else begin
          state_d = ST_FINE;
        end
      end
      ST_FINE: begin
        if (!sig_q[MSB] && (exp_q > EXP_REG_W'(1))) begin
          sig_d = sig_q << 1;
          exp_d = exp_q - EXP_REG_W'(1);
        end else begin
          // Leading one still missing means the exponent floor stopped us.
          sub_d     = ~sig_q[MSB];
          exp_out_d = sig_q[MSB] ? exp_q[EXP_WIDTH-1:0] : '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sig_q     <= '0;
      exp_q     <= '0;
      exp_out_q <= '0;
      sticky_q  <= 1'b0;
      zero_q    <= 1'b0;
      sub_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      exp_q     <= exp_d;
      exp_out_q <= exp_out_d;
      sticky_q  <= sticky_d;
      zero_q    <= zero_d;
      sub_q     <= sub_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.sig_out      = sig_q;
  assign bus.exp_out      = exp_out_q;
  assign bus.sticky_out   = sticky_q;
  assign bus.is_zero      = zero_q;
  assign bus.is_subnormal = sub_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_fma_normalizer.sv
// Bench for fma_normalizer: directed cases with literal results plus randomized operands
// checked against a leading-one/shift-count model of the normalization rules.
module tb_fma_normalizer;
  import fma_normalizer_pkg::*;

  typedef struct {
    logic [74:0] sig;
    logic [7:0]  exp;
    logic        sticky;
    logic        zero;
    logic        sub;
    logic        ovf;
    int          lat;
    int          accept;
    bit          seen;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fma_normalizer_if bus();

  fma_normalizer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  exp_t q[$];

  logic [74:0] last_sig;
  logic [7:0]  last_exp;
  logic [3:0]  last_flags;
  int          last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [75:0] a, input logic [75:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, b);
    end
  endfunction

  // Expected result from the leading-one position: s left shifts are wanted, coarse steps
  // take 8 at a time while the exponent stays above 8, fine steps stop at exponent 1.
  function automatic exp_t model(input logic [75:0] s, input logic [7:0] e_in);
    exp_t r;
    int p, sh, e, nc, nf, rem;
    r.sig = '0; r.exp = '0; r.sticky = 0; r.zero = 0; r.sub = 0; r.ovf = 0;
    r.lat = 0; r.accept = 0; r.seen = 0;
    if (s == '0) begin
      r.zero = 1; r.lat = 1;
      return r;
    end
    if (s[75]) begin
      e = int'(e_in) + 1;
      r.sticky = s[0];
      r.sig = s[75:1];
      if (e >= 255) begin
        r.ovf = 1; r.exp = 8'hFF; r.lat = 1;
      end else begin
        r.exp = 8'(e); r.lat = 3;
      end
      return r;
    end
    p = 0;
    for (int i = 0; i < 75; i++) if (s[i]) p = i;
    sh = 74 - p;
    e = int'(e_in);
    nc = sh / 8;
    if (e <= 8) nc = 0;
    else if ((e - 9) / 8 + 1 < nc) nc = (e - 9) / 8 + 1;
    e = e - 8 * nc;
    rem = sh - 8 * nc;
    nf = (e > 1) ? ((e - 1 < rem) ? e - 1 : rem) : 0;
    r.sig = s[74:0] << (8 * nc + nf);
    r.sub = (nf < rem);
    r.exp = r.sub ? 8'd0 : 8'(e - nf);
    r.lat = nc + nf + 3;
    return r;
  endfunction

  // Compare process: checks every cycle the result is presented, and records accepts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
      end else begin
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            errors++; checks++;
            $display("FAIL spurious_out_valid: got 1 expected 0");
          end else begin
            e = q[0];
            chk("sig_out", 76'(bus.sig_out), 76'(e.sig));
            chk("exp_out", 76'(bus.exp_out), 76'(e.exp));
            chk("flags", 76'({bus.sticky_out, bus.is_zero, bus.is_subnormal, bus.overflow}),
                76'({e.sticky, e.zero, e.sub, e.ovf}));
            chk("in_ready_in_done", 76'(bus.in_ready), 76'(0));
            if (!e.seen) begin
              chk("latency", 76'(cyc - e.accept + 1), 76'(e.lat));
              last_sig   = bus.sig_out;
              last_exp   = bus.exp_out;
              last_flags = {bus.sticky_out, bus.is_zero, bus.is_subnormal, bus.overflow};
              last_lat   = cyc - e.accept + 1;
              q[0].seen  = 1;
            end
            if (bus.out_ready) begin
              void'(q.pop_front());
              done_cnt++;
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e = model(bus.sum_in, bus.exp_in);
          e.accept = cyc + 1;
          q.push_back(e);
          acc_cnt++;
        end
      end
    end
  end

  task automatic timeout(input string n);
    errors++; checks++;
    $display("FAIL timeout_%s: got no event expected event within 300 cycles", n);
  endtask

  task automatic wait_acc(input int a0);
    int n = 0;
    while (acc_cnt == a0 && n < 300) begin @(posedge clk); #1; n++; end
    if (acc_cnt == a0) timeout("accept");
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus.out_valid) timeout("out_valid");
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); #1; n++; end
    if (done_cnt == d0) timeout("done");
  endtask

  task automatic xact(input logic [75:0] s, input logic [7:0] e, input int hold);
    int a0 = acc_cnt;
    int d0 = done_cnt;
    @(posedge clk); #1;
    bus.sum_in = s; bus.exp_in = e; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    wait_acc(a0);
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      wait_valid();
      repeat (hold) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
    end
    wait_done(d0);
  endtask

  // flags packed as {sticky, zero, subnormal, overflow}
  task automatic pin(input string n, input logic [74:0] s, input logic [7:0] e,
                     input logic [3:0] f, input int lat);
    chk({n, "_sig"}, 76'(last_sig), 76'(s));
    chk({n, "_exp"}, 76'(last_exp), 76'(e));
    chk({n, "_flags"}, 76'(last_flags), 76'(f));
    chk({n, "_lat"}, 76'(last_lat), 76'(lat));
  endtask

  function automatic logic [75:0] rnd_sum();
    logic [95:0] w;
    int k, lead;
    w = {$urandom, $urandom, $urandom};
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k == 1) return {1'b1, w[74:0]};
    lead = $urandom_range(0, 74);
    return (w[75:0] & ((76'd1 << (lead + 1)) - 76'd1)) | (76'd1 << lead);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t m;
    logic [74:0] snap_sig;
    logic [7:0]  snap_exp;
    logic [75:0] s;
    logic [7:0]  e;
    int a0, d0;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.sum_in = '0; bus.exp_in = '0;
    #23;
    chk("rst_in_ready", 76'(bus.in_ready), 76'(1));
    chk("rst_out_valid", 76'(bus.out_valid), 76'(0));
    chk("rst_data", 76'({bus.sig_out, bus.exp_out}), 76'(0));
    chk("rst_flags", 76'({bus.sticky_out, bus.is_zero, bus.is_subnormal, bus.overflow}), 76'(0));
    reset_n = 1'b1;

    // Pin the model itself against hand-worked results.
    m = model(76'd1 << 60, 8'd127);
    chk("model_exp_113", 76'(m.exp), 76'(113));
    chk("model_lat_10", 76'(m.lat), 76'(10));
    m = model(76'd1 << 60, 8'd5);
    chk("model_sub", 76'({m.sub, m.exp}), 76'({1'b1, 8'd0}));

    xact(76'd1 << 74, 8'd127, 0);
    pin("aligned", 75'd1 << 74, 8'd127, 4'b0000, 3);
    xact(76'd1 << 60, 8'd127, 0);
    pin("shift14", 75'd1 << 74, 8'd113, 4'b0000, 10);
    xact((76'd1 << 75) | 76'd1, 8'd127, 0);
    pin("carry", 75'd1 << 74, 8'd128, 4'b1000, 3);
    xact((76'd1 << 75) | 76'd1, 8'd254, 0);
    pin("overflow", 75'd1 << 74, 8'd255, 4'b1001, 1);
    xact(76'd1 << 60, 8'd5, 0);
    pin("subnormal", 75'd1 << 64, 8'd0, 4'b0010, 7);
    xact(76'd0, 8'd99, 0);
    pin("zero", 75'd0, 8'd0, 4'b0100, 1);

    // Backpressure: result held 5 cycles while a second operand waits.
    a0 = acc_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    bus.sum_in = 76'd1 << 50; bus.exp_in = 8'd100; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_acc(a0);
    bus.in_valid = 1'b0;
    wait_valid();
    snap_sig = bus.sig_out; snap_exp = bus.exp_out;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.sum_in = 76'd1 << 74; bus.exp_in = 8'd200; bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("bp_in_ready", 76'(bus.in_ready), 76'(0));
      chk("bp_stable", 76'({bus.sig_out, bus.exp_out}), 76'({snap_sig, snap_exp}));
    end
    chk("bp_no_accept", 76'(acc_cnt), 76'(a0 + 1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 76'(bus.in_ready), 76'(1));
    chk("bp_released", 76'(done_cnt), 76'(d0 + 1));
    wait_acc(a0 + 1);
    bus.in_valid = 1'b0;
    wait_done(d0 + 1);
    pin("bp_second", 75'd1 << 74, 8'd200, 4'b0000, 3);

    // Asynchronous reset while shifting coarsely.
    a0 = acc_cnt;
    @(posedge clk); #1;
    bus.sum_in = 76'd1 << 20; bus.exp_in = 8'd127; bus.in_valid = 1'b1;
    wait_acc(a0);
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready", 76'(bus.in_ready), 76'(1));
    chk("arst_out_valid", 76'(bus.out_valid), 76'(0));
    chk("arst_data", 76'({bus.sig_out, bus.exp_out}), 76'(0));
    chk("arst_flags", 76'({bus.sticky_out, bus.is_zero, bus.is_subnormal, bus.overflow}), 76'(0));
    #20;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release_ready", 76'(bus.in_ready), 76'(1));
    xact(76'd1 << 60, 8'd127, 0);
    pin("after_rst", 75'd1 << 74, 8'd113, 4'b0000, 10);

    // Randomized operands with occasional backpressure.
    for (int t = 0; t < 150; t++) begin
      s = rnd_sum();
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 12));
        1:       e = 8'($urandom_range(245, 254));
        default: e = 8'($urandom_range(0, 254));
      endcase
      xact(s, e, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
